// File: rtl/cpu_control_unit.sv
// Control-unit FSM for the 4-bit-address teaching CPU: sequences BOOT/FETCH/LOAD/DECODE/EXEC/HALT.
// Latency: 4 cycles per instruction (FETCH, LOAD, DECODE, EXEC); outputs are Moore except Zero in EXEC.
// Backpressure: Run=0 holds the FSM in FETCH; Run is ignored in every other state.
`timescale 1ns/1ps
module cpu_control_unit #(
  parameter int          CNT_W   = 8,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [3:0]       IRCU,
  input  logic             Zero,
  output logic             IRload,
  output logic             PCload,
  output logic [1:0]       JSM,
  output logic             ANSload,
  output logic             select_mode,
  output logic             Aload,
  output logic             Bload,
  output logic [2:0]       ALUop,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // PC source encodings
  localparam logic [1:0] JSM_INC = 2'd0;
  localparam logic [1:0] JSM_IR  = 2'd1;
  localparam logic [1:0] JSM_VEC = 2'd2;

  state_t           state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ungated strobes decoded from state and latched opcode
  logic       ir_load, pc_load, ans_load, sel_mode, a_load, b_load, halted;
  logic [1:0] jsm;
  logic [2:0] alu_op;

  // State, opcode and retired-instruction counter registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_BOOT;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and output decode; defaults first so every path is covered
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    jsm      = JSM_INC;
    ans_load = 1'b0;
    sel_mode = 1'b0;
    a_load   = 1'b0;
    b_load   = 1'b0;
    alu_op   = 3'd0;
    halted   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_load = 1'b1;
        jsm     = JSM_VEC;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // ROM is reading PC this cycle; only here may the CPU be paused
        if (Run) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // IR takes the ROM word while PC advances on the same edge
        ir_load = 1'b1;
        pc_load = 1'b1;
        jsm     = JSM_INC;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        opcode_d = IRCU;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode_q == HALT_OP) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          cnt_d   = cnt_q + CNT_W'(1);
          case (opcode_q)
            4'h1: a_load = 1'b1;
            4'h2: b_load = 1'b1;
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
              alu_op   = 3'(opcode_q - 4'd3);
              sel_mode = 1'b1;
              a_load   = 1'b1;
            end
            4'h9: ans_load = 1'b1;
            4'hA: begin
              pc_load = 1'b1;
              jsm     = JSM_IR;
            end
            // Conditional jumps keep JSM at 0 when not taken so JSM is
            // never non-zero without PCload
            4'hB: begin
              pc_load = Zero;
              jsm     = Zero ? JSM_IR : JSM_INC;
            end
            4'hC: begin
              pc_load = ~Zero;
              jsm     = Zero ? JSM_INC : JSM_IR;
            end
            4'hD: begin
              pc_load = 1'b1;
              jsm     = JSM_VEC;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Reset gates every strobe immediately, even mid-instruction
  assign IRload      = ir_load  & Reset;
  assign PCload      = pc_load  & Reset;
  assign JSM         = Reset ? jsm : 2'b00;
  assign ANSload     = ans_load & Reset;
  assign select_mode = sel_mode & Reset;
  assign Aload       = a_load   & Reset;
  assign Bload       = b_load   & Reset;
  assign ALUop       = Reset ? alu_op : 3'd0;
  assign Halted      = halted   & Reset;
  assign InstrCount  = cnt_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: instruction-level reference model feeding a per-cycle scoreboard.
// Latency: driver pushes one expected output vector per cycle; monitor pops on the falling edge.
// Backpressure: Run=0 stall cycles are issued from the instruction generator.
`timescale 1ns/1ps
module tb_cpu_control_unit;

  localparam int CNT_W = 8;

  logic             Clk   = 1'b0;
  logic             Reset = 1'b0;
  logic             Run   = 1'b0;
  logic [3:0]       IRCU  = 4'h0;
  logic             Zero  = 1'b0;
  logic             IRload, PCload, ANSload, select_mode, Aload, Bload, Halted;
  logic [1:0]       JSM;
  logic [2:0]       ALUop;
  logic [CNT_W-1:0] InstrCount;

  cpu_control_unit #(.CNT_W(CNT_W), .HALT_OP(4'hF)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .IRCU(IRCU), .Zero(Zero),
    .IRload(IRload), .PCload(PCload), .JSM(JSM), .ANSload(ANSload),
    .select_mode(select_mode), .Aload(Aload), .Bload(Bload), .ALUop(ALUop),
    .Halted(Halted), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  // Vector layout: {IRload, PCload, JSM[1:0], ANSload, select_mode, Aload, Bload, ALUop[2:0], Halted, InstrCount[7:0]}
  typedef struct {
    logic [19:0] v;
    int          kind;
  } exp_t;

  localparam int K_RESET = 0, K_BOOT = 1, K_FETCH = 2, K_LOAD = 3, K_DECODE = 4, K_EXEC = 5, K_HALT = 6;

  exp_t q[$];
  bit   mon_en  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   retired = 0;

  wire [19:0] act = {IRload, PCload, JSM, ANSload, select_mode, Aload, Bload, ALUop, Halted, InstrCount};

  function automatic string kname(input int k);
    case (k)
      K_RESET:  return "reset";
      K_BOOT:   return "boot";
      K_FETCH:  return "fetch";
      K_LOAD:   return "load";
      K_DECODE: return "decode";
      K_EXEC:   return "exec";
      default:  return "halt";
    endcase
  endfunction

  function automatic logic [19:0] pack(input logic ir, input logic pc, input logic [1:0] jsm,
                                       input logic ans, input logic sel, input logic a, input logic b,
                                       input logic [2:0] alu, input logic hlt, input logic [7:0] cnt);
    return {ir, pc, jsm, ans, sel, a, b, alu, hlt, cnt};
  endfunction

  // Retired count as seen on InstrCount: modulo 2^CNT_W
  function automatic logic [7:0] cnt_exp();
    return 8'(retired % (1 << CNT_W));
  endfunction

  // EXEC-cycle strobes straight from the opcode table
  function automatic logic [19:0] exec_exp(input logic [3:0] op, input logic z, input logic [7:0] c);
    logic       pc, ans, sel, a, b;
    logic [1:0] jsm;
    logic [2:0] alu;
    pc = 0; ans = 0; sel = 0; a = 0; b = 0; jsm = 0; alu = 0;
    if (op == 4'h1) a = 1;
    else if (op == 4'h2) b = 1;
    else if (op >= 4'h3 && op <= 4'h8) begin a = 1; sel = 1; alu = 3'(op - 4'd3); end
    else if (op == 4'h9) ans = 1;
    else if (op == 4'hA) begin pc = 1; jsm = 2'd1; end
    else if (op == 4'hB) begin if (z) begin pc = 1; jsm = 2'd1; end end
    else if (op == 4'hC) begin if (!z) begin pc = 1; jsm = 2'd1; end end
    else if (op == 4'hD) begin pc = 1; jsm = 2'd2; end
    return pack(1'b0, pc, jsm, ans, sel, a, b, alu, 1'b0, c);
  endfunction

  task automatic check(input string name, input logic [19:0] a, input logic [19:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
    end
  endtask

  // Monitor: one expected vector per cycle, compared away from the rising edge
  always @(negedge Clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty cycle %0d: got %h expected nothing queued", cyc, act);
      end else begin
        exp_t e;
        e = q.pop_front();
        check(kname(e.kind), act, e.v);
      end
    end
  end

  task automatic drive(input logic rst, input logic run, input logic [3:0] ircu, input logic z,
                       input logic [19:0] ev, input int kind);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = rst;
    Run   = run;
    IRCU  = ircu;
    Zero  = z;
    e.v    = ev;
    e.kind = kind;
    q.push_back(e);
    cyc++;
  endtask

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, r1(), r4(), r1(), 20'h0, K_RESET);
    retired = 0;
    drive(1'b1, r1(), r4(), r1(), pack(0, 1, 2'd2, 0, 0, 0, 0, 3'd0, 0, 8'd0), K_BOOT);
  endtask

  task automatic instr(input logic [3:0] op, input logic z, input int stall);
    logic [7:0] c;
    c = cnt_exp();
    for (int i = 0; i < stall; i++)
      drive(1'b1, 1'b0, r4(), r1(), pack(0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, c), K_FETCH);
    drive(1'b1, 1'b1, r4(), r1(), pack(0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, c), K_FETCH);
    drive(1'b1, r1(), r4(), r1(), pack(1, 1, 2'd0, 0, 0, 0, 0, 3'd0, 0, c), K_LOAD);
    drive(1'b1, r1(), op,   r1(), pack(0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 0, c), K_DECODE);
    drive(1'b1, r1(), r4(), z,    exec_exp(op, z, c), K_EXEC);
    if (op != 4'hF) retired++;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, r1(), r4(), r1(), pack(0, 0, 2'd0, 0, 0, 0, 0, 3'd0, 1, cnt_exp()), K_HALT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    mon_en = 1'b1;
    do_reset(3);

    // Basic load/ALU/output sequence; the next FETCH sees InstrCount = 4
    instr(4'h1, r1(), 0);
    instr(4'h2, r1(), 0);
    instr(4'h3, r1(), 0);
    instr(4'h9, r1(), 0);

    // Conditional jumps both ways
    instr(4'hB, 1'b1, 0);
    instr(4'hB, 1'b0, 0);
    instr(4'hC, 1'b1, 0);
    instr(4'hC, 1'b0, 0);

    // Five stalled FETCH cycles
    instr(4'h0, r1(), 5);

    // Every non-halt opcode with both Zero values
    for (int op = 0; op < 15; op++) begin
      instr(4'(op), 1'b0, 0);
      instr(4'(op), 1'b1, 0);
    end

    // Random program with random stalls
    for (int i = 0; i < 80; i++)
      instr(4'($urandom_range(0, 14)), r1(), $urandom_range(0, 2));

    // HALT holds for 20 cycles with count frozen, then reset recovers
    instr(4'hF, r1(), 0);
    halt_cycles(20);
    do_reset(2);

    // Counter wraps after 2^CNT_W retirements
    for (int i = 0; i < (1 << CNT_W); i++)
      instr(r1() ? 4'hE : 4'h0, r1(), 0);
    instr(4'h1, r1(), 0);

    // Asynchronous reset in the middle of an ADD EXEC cycle
    instr(4'h3, r1(), 0);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("async_reset_mid_exec", act, 20'h0);
    do_reset(2);
    instr(4'h4, r1(), 1);
    instr(4'hA, r1(), 0);

    @(negedge Clk);
    #1;
    mon_en = 1'b0;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
